// File: rtl/std_cache_pkg.sv
// ============================================================================
// Module      : std_cache_pkg
// Description : Shared cache-subsystem types and constants: the flush
//               controller state encoding and the flush requester indices.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package std_cache_pkg;

    // Flush controller sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } flush_ctrl_state_t;

    // Bit positions of the individual flush requesters
    localparam int FLUSH_FENCE  = 0;
    localparam int FLUSH_FENCEI = 1;
    localparam int FLUSH_CSR    = 2;

endpackage : std_cache_pkg

`default_nettype wire

// File: rtl/dcache_flush_ctrl_watchdog.sv
// ============================================================================
// Module      : flush_watchdog
// Description : Saturating cycle counter guarding the FLUSH phase. Produces a
//               single expire pulse when the count reaches its last value and
//               then holds there until cleared.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module flush_watchdog #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int                CNT_W  = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  c_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;
    logic             r_fired;

    // Count enabled cycles, stop at the last value and remember the pulse was given
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_fired <= 1'b0;
        end else if (i_clear) begin
            r_count <= '0;
            r_fired <= 1'b0;
        end else if (i_enable) begin
            if (r_count == c_LAST) begin
                r_fired <= 1'b1;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    // Pulse exactly once, in the enabled cycle that sits on the last count
    assign o_expire = i_enable & (r_count == c_LAST) & ~r_fired;

endmodule : flush_watchdog

`default_nettype wire

// File: rtl/dcache_flush_ctrl.sv
// ============================================================================
// Module      : dcache_flush_ctrl
// Description : Arbitrates flush requests from several requesters, drains the
//               write buffer, issues a single dcache flush per batch and
//               returns per-requester completion pulses. Requests arriving
//               while the flush is in flight are batched for a follow-up pass.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcache_flush_ctrl
    import std_cache_pkg::*;
#(
    parameter int NR_REQ         = 3,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NR_REQ-1:0] flush_req_i,
    output logic [NR_REQ-1:0] flush_done_o,
    input  logic              wbuffer_empty_i,
    output logic              dcache_flush_o,
    input  logic              dcache_flush_ack_i,
    output logic              stall_o,
    output logic              timeout_o,
    output logic              busy_o
);

    flush_ctrl_state_t r_state;
    logic [NR_REQ-1:0] r_active;    // requesters covered by the current flush
    logic [NR_REQ-1:0] r_pending;   // requesters queued for the next flush
    logic [NR_REQ-1:0] r_serviced;  // done already given, waiting for request to drop
    logic [NR_REQ-1:0] r_done;

    logic [NR_REQ-1:0] w_fresh;
    logic              w_wd_clear;
    logic              w_wd_enable;

    // A request is eligible only once its previous completion has been acknowledged by a low level
    assign w_fresh     = flush_req_i & ~r_serviced;
    assign w_wd_clear  = (r_state == DRAIN) && wbuffer_empty_i;
    assign w_wd_enable = (r_state == FLUSH);

    // Main sequencer: request capture, drain, flush, completion and batching
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_active   <= '0;
            r_pending  <= '0;
            r_serviced <= '0;
            r_done     <= '0;
        end else begin
            r_done     <= '0;
            r_serviced <= (r_serviced & flush_req_i)
                        | ((r_state == DONE) ? r_active : '0);
            case (r_state)
                IDLE: begin
                    if (|w_fresh) begin
                        r_active <= w_fresh;
                        r_state  <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Late arrivals still ride on this flush
                    r_active <= r_active | w_fresh;
                    if (wbuffer_empty_i) begin
                        r_state <= FLUSH;
                    end
                end
                FLUSH: begin
                    // The dcache is already flushing; newcomers need a second pass
                    r_pending <= r_pending | (w_fresh & ~r_active);
                    if (dcache_flush_ack_i) begin
                        r_done  <= r_active;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (|r_pending) begin
                        r_active  <= r_pending;
                        r_pending <= '0;
                        r_state   <= DRAIN;
                    end else begin
                        r_active  <= '0;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    flush_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .i_clear  (w_wd_clear),
        .i_enable (w_wd_enable),
        .o_expire (timeout_o)
    );

    // Outputs decode registered state only, so no input reaches them combinationally
    assign busy_o         = (r_state != IDLE);
    assign stall_o        = (r_state != IDLE);
    assign dcache_flush_o = (r_state == FLUSH);
    assign flush_done_o   = r_done;

endmodule : dcache_flush_ctrl

`default_nettype wire
